// File: rtl/muldiv_iter_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_iter_pkg;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [31:0] MD_ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] MD_INT_MIN  = 32'h8000_0000;
    localparam logic [5:0]  MD_LAST_BIT = 6'd31;

    // Divide/remainder ops all have funct3[2] set.
    function automatic logic f3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate; turns signed values into magnitudes
// and magnitudes back into signed results.
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    // Negate when requested, otherwise pass through.
    always_comb begin
        res = neg ? (~val + W'(1)) : val;
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide: one bit per cycle, fixed 34-cycle latency,
// single-cycle fast path for divide-by-zero and signed overflow.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | 32 shift-add / shift-subtract iterations
// FIX   | sign fix-up and word select into r
// DONE  | valid pulse; new start accepted here
module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [TAGW-1:0] tag_in,
    output logic            ready,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] r,
    output logic [TAGW-1:0] tag_out
);

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [TAGW-1:0]   tag_q, tag_d;
    logic              neg_q, neg_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [63:0]       acc_q, acc_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   r_q, r_d;
    logic [TAGW-1:0]   tag_out_q, tag_out_d;
    logic              ready_q, busy_q, valid_q;

    logic              signed_a, signed_b, res_neg;
    logic              div_zero, sgn_ovf;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [32:0]       mul_sum;
    logic [32:0]       rem_sh;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_sub;
    logic [63:0]       fix_in, fix_out;

    // Operand signedness and result sign decoded from the launching funct3.
    always_comb begin
        signed_a = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV)  || (funct3 == F3_REM);
        signed_b = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        case (funct3)
            F3_MULH, F3_DIV:   res_neg = a[31] ^ b[31];
            F3_MULHSU, F3_REM: res_neg = a[31];
            default:           res_neg = 1'b0;
        endcase
        div_zero = (b == '0);
        sgn_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                   (a == MD_INT_MIN) && (b == MD_ALL_ONES);
    end

    muldiv_signfix #(.W(XLEN)) u_fix_a (.val(a), .neg(signed_a & a[31]), .res(a_mag));
    muldiv_signfix #(.W(XLEN)) u_fix_b (.val(b), .neg(signed_b & b[31]), .res(b_mag));

    // Per-iteration datapath: multiply adds into the high half then shifts
    // right; divide shifts the dividend MSB into the remainder and restores.
    always_comb begin
        mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
        rem_sh  = {rem_q, acc_q[31]};
        rem_ge  = (rem_sh >= {1'b0, mcand_q});
        rem_sub = rem_sh[31:0] - mcand_q;
    end

    // Result fix-up input: full product, or zero-extended quotient/remainder
    // (negating the 64-bit extension leaves the correct low word).
    always_comb begin
        if (f3_is_div(op_q)) begin
            fix_in = op_q[1] ? {32'b0, rem_q} : {32'b0, acc_q[31:0]};
        end else begin
            fix_in = acc_q;
        end
    end

    muldiv_signfix #(.W(64)) u_fix_r (.val(fix_in), .neg(neg_q), .res(fix_out));

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        tag_d     = tag_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        mcand_d   = mcand_q;
        r_d       = r_q;
        tag_out_d = tag_out_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start && !flush) begin
                    op_d  = funct3;
                    tag_d = tag_in;
                    cnt_d = '0;
                    if (f3_is_div(funct3) && div_zero) begin
                        r_d       = funct3[1] ? a : MD_ALL_ONES;
                        tag_out_d = tag_in;
                        state_d   = ST_DONE;
                    end else if (sgn_ovf) begin
                        r_d       = funct3[1] ? '0 : MD_INT_MIN;
                        tag_out_d = tag_in;
                        state_d   = ST_DONE;
                    end else begin
                        neg_d   = res_neg;
                        rem_d   = '0;
                        state_d = ST_CALC;
                        if (f3_is_div(funct3)) begin
                            acc_d   = {32'b0, a_mag};
                            mcand_d = b_mag;
                        end else begin
                            acc_d   = {32'b0, b_mag};
                            mcand_d = a_mag;
                        end
                    end
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    if (f3_is_div(op_q)) begin
                        rem_d        = rem_ge ? rem_sub : rem_sh[31:0];
                        acc_d[31:0]  = {acc_q[30:0], rem_ge};
                    end else begin
                        acc_d = {mul_sum, acc_q[31:1]};
                    end
                    if (cnt_q == MD_LAST_BIT) begin
                        state_d = ST_FIX;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            ST_FIX: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    r_d       = (f3_is_div(op_q) || op_q == F3_MUL) ? fix_out[31:0]
                                                                    : fix_out[63:32];
                    tag_out_d = tag_q;
                    state_d   = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            tag_q     <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            mcand_q   <= '0;
            r_q       <= '0;
            tag_out_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            neg_q     <= neg_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            mcand_q   <= mcand_d;
            r_q       <= r_d;
            tag_out_q <= tag_out_d;
            ready_q   <= (state_d == ST_IDLE) || (state_d == ST_DONE);
            busy_q    <= (state_d == ST_CALC) || (state_d == ST_FIX);
            valid_q   <= (state_d == ST_DONE);
        end
    end

    assign ready   = ready_q;
    assign busy    = busy_q;
    assign valid   = valid_q;
    assign r       = r_q;
    assign tag_out = tag_out_q;

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
Iterative RV32M multiply/divide unit sitting in the EX stage beside the ALU. It accepts operands already bypassed in ID and returns a 32-bit result plus a destination tag to the MA stage. One bit per cycle; divide-by-zero and signed-overflow take a single-cycle fast path. The core stalls IF/ID/EX while busy is high and squashes an in-flight operation with flush.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
TAGW, 5, width of the destination-register tag carried alongside the operation.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  launch request; sampled only when ready is high
flush  in  1  abort current op (branch/jump squash); has priority over start
funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  in  32  rs1 operand
b  in  32  rs2 operand
tag_in  in  TAGW  rd address of the launching instruction
ready  out  1  high in IDLE and DONE; start is accepted
busy  out  1  high in CALC and FIX
valid  out  1  one-cycle pulse; r and tag_out hold the result
r  out  32  result; holds its value until the next completion
tag_out  out  TAGW  tag_in captured at launch

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, valid=0, r=0, tag_out=0, counter=0. Reset mid-operation discards the op with no valid pulse.
- States: IDLE, CALC, FIX, DONE. valid=1 only in DONE. DONE lasts exactly one cycle.
- Launch edge (E0): start&ready&~flush.
  - Captures funct3 and tag_in.
  - Computes operand magnitudes and the result sign.
  - MULH and DIV/REM treat both operands as signed.
  - MULHSU treats a as signed and b as unsigned.
  - MULHU and DIVU/REMU are fully unsigned.
  - MUL uses the low word, which is sign-agnostic.
- Fast path at E0 goes straight to DONE, so valid is high in the cycle after E0 (latency 1):
  - Divide by zero (b==0): DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
  - Signed overflow (a==0x80000000, b==0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Normal path: E0 -> CALC with counter=0.
  - Each CALC edge processes one bit.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract with a 33-bit partial remainder.
  - After 32 CALC edges (E1..E32) -> FIX.
  - E33 applies two's-complement negation where required and selects the hi/lo word or quotient/remainder into r, then -> DONE.
  - valid is high in the cycle after E33 (latency 34, fixed and data-independent).
- Sign rules:
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Product is negated iff the signs differ (MULHSU: sign of a only).
- Back-to-back: start in DONE is accepted; the DONE pulse still completes and the next state is CALC (or DONE again for the fast path).
- flush in CALC/FIX: next state IDLE, no valid, r unchanged.
- flush in DONE: valid is already asserted that cycle and is not retracted; the next state is IDLE and any concurrent start is ignored.
- start while busy is ignored.
- Counter is 6 bits and compares against 31. There is no wrap-around because the counter is reset at every launch.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - funct3 encodings for MUL..REMU;
  - state encoding (IDLE=0, CALC=1, FIX=2, DONE=3);
  - the constants 0xFFFFFFFF and 0x80000000 used by the fast path.
- One natural sub-module, muldiv_signfix: combinational magnitude/negate helper, instantiated for operand conditioning and for result fix-up.
- Datapath plus FSM stays in muldiv_iter, roughly 200 lines.

Test Plan:
- MUL a=7, b=0xFFFFFFFD -> r=0xFFFFFFEB. valid pulses exactly 34 cycles after the launch edge; busy high for 33 cycles; tag_out=tag_in.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Fast path: DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0. Each gives valid 1 cycle after launch with busy never high.
- Flush: launch DIV, assert flush at CALC cycle 10 -> no valid, ready next cycle, r keeps its prior value. A new MUL 3*4 launched afterwards -> r=12.
- Reset: drop rst_n mid-CALC -> busy, valid, r and tag_out go to 0 without waiting for clk. After release, start with back-to-back DONE->launch -> two valid pulses 34 cycles apart with correct results.
